// File: rtl/ofdm_tx_input_buffer_pp_if.sv
// Bus bundle for the OFDM Tx ping-pong input buffer: AXI4-Lite slave
// channels from the PS interconnect plus the AXI4-Stream output toward
// the modulator. The "slave" modport is the buffer's own view; "master"
// is the view of whatever drives the CPU side and sinks the stream.
interface ofdm_tx_input_buffer_pp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [ADDR_WIDTH-1:0]   s_axi_araddr;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]              s_axi_rresp;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;
  logic [DATA_WIDTH-1:0]   m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic                    m_axis_tlast;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready, m_axis_tready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready,
           s_axi_rdata, s_axi_rresp, s_axi_rvalid, m_axis_tdata, m_axis_tvalid,
           m_axis_tlast
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready, m_axis_tready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready,
           s_axi_rdata, s_axi_rresp, s_axi_rvalid, m_axis_tdata, m_axis_tvalid,
           m_axis_tlast
  );
endinterface

// File: rtl/ofdm_tx_input_buffer_pp.sv
// OFDM Tx ping-pong input buffer. The CPU fills one bank of N words over
// AXI4-Lite; writing word N-1 commits the bank and flips the writer to the
// other bank. Committed banks are streamed out on AXI4-Stream in commit
// order, back-to-back when both are full. Writes to a still-full fill bank
// are dropped and flagged through a sticky overflow bit.
module ofdm_tx_input_buffer_pp #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 8,
  parameter int WORDS_PER_SYMBOL = 7
) (
  input  logic                    aclk,
  input  logic                    areset,
  ofdm_tx_input_buffer_pp_if.slave bus
);
  localparam int N  = WORDS_PER_SYMBOL;
  localparam int IW = ADDR_WIDTH - 2;
  localparam int MW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] CTRL_IDX = '1;
  localparam logic [MW-1:0] LAST_RD  = MW'(N - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [2][N];
  logic [1:0]            bank_full, bank_full_nxt;
  logic                  fill_bank, drain_bank, overflow;
  logic [7:0]            sym_cnt;
  logic [MW-1:0]         rd_idx;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [IW-1:0] wr_idx, ar_idx;
  logic [MW-1:0] wr_widx;
  logic          wr_acc, ar_acc, wr_data, wr_ovf, wr_mem, commit, ctrl_clr;
  logic          streaming, beat, last_beat;
  logic [15:0]   status16;
  logic          unused_ok;

  assign wr_idx  = bus.s_axi_awaddr[ADDR_WIDTH-1:2];
  assign ar_idx  = bus.s_axi_araddr[ADDR_WIDTH-1:2];
  assign wr_widx = wr_idx[MW-1:0];

  // One write and one read outstanding at a time; ready is offered in the
  // same cycle the request is seen so acceptance is a single-cycle pulse.
  assign wr_acc   = bus.s_axi_awvalid & bus.s_axi_wvalid & ~bvalid_q & ~areset;
  assign ar_acc   = bus.s_axi_arvalid & ~rvalid_q & ~areset;
  assign wr_data  = wr_idx <= LAST_IDX;
  assign wr_ovf   = wr_acc & wr_data & bank_full[fill_bank];
  assign wr_mem   = wr_acc & wr_data & ~bank_full[fill_bank];
  assign commit   = wr_mem & (wr_idx == LAST_IDX);
  // bit1 (abandon partial fill) needs no action: the partially written
  // words are simply overwritten or left stale until the next commit.
  assign ctrl_clr = wr_acc & (wr_idx == CTRL_IDX) & bus.s_axi_wstrb[0] & bus.s_axi_wdata[0];

  assign streaming = (state == S_STREAM);
  assign beat      = streaming & bus.m_axis_tready;
  assign last_beat = beat & (rd_idx == LAST_RD);

  assign status16  = {sym_cnt, 3'b000, overflow, drain_bank, fill_bank, bank_full};
  assign unused_ok = ^{bus.s_axi_awaddr[1:0], bus.s_axi_araddr[1:0]};

  assign bus.s_axi_awready = wr_acc;
  assign bus.s_axi_wready  = wr_acc;
  assign bus.s_axi_bvalid  = bvalid_q;
  assign bus.s_axi_bresp   = bresp_q;
  assign bus.s_axi_arready = ar_acc;
  assign bus.s_axi_rvalid  = rvalid_q;
  assign bus.s_axi_rdata   = rdata_q;
  assign bus.s_axi_rresp   = 2'b00;
  assign bus.m_axis_tvalid = streaming;
  assign bus.m_axis_tdata  = streaming ? mem[drain_bank][rd_idx] : '0;
  assign bus.m_axis_tlast  = streaming & (rd_idx == LAST_RD);

  // Commit and last-beat drain touch different banks, so both apply.
  always_comb begin
    bank_full_nxt = bank_full;
    if (commit)    bank_full_nxt[fill_bank]  = 1'b1;
    if (last_beat) bank_full_nxt[drain_bank] = 1'b0;
  end

  // Next-state uses the post-edge full flags so a commit starts the stream
  // one cycle later and a full partner bank follows with no bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bank_full_nxt[drain_bank]) state_nxt = S_STREAM;
      S_STREAM: if (last_beat && !bank_full_nxt[~drain_bank]) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Stream FSM state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Bank bookkeeping, drain pointer, symbol counter and overflow sticky.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bank_full  <= '0;
      fill_bank  <= 1'b0;
      drain_bank <= 1'b0;
      rd_idx     <= '0;
      overflow   <= 1'b0;
      sym_cnt    <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      if (commit) begin
        fill_bank <= ~fill_bank;
        sym_cnt   <= sym_cnt + 8'd1;
      end
      if (beat)      rd_idx <= last_beat ? '0 : rd_idx + MW'(1);
      if (last_beat) drain_bank <= ~drain_bank;
      if (wr_ovf)        overflow <= 1'b1;
      else if (ctrl_clr) overflow <= 1'b0;
    end
  end

  // Write response: SLVERR only for a data write dropped on a full bank.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else if (wr_acc) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_ovf ? 2'b10 : 2'b00;
    end else if (bus.s_axi_bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // Read response: only STATUS returns content; everything else reads 0.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_acc) begin
      rvalid_q <= 1'b1;
      rdata_q  <= (ar_idx == CTRL_IDX) ? DATA_WIDTH'(status16) : '0;
    end else if (bus.s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Symbol storage with byte-lane writes; contents survive reset.
  always_ff @(posedge aclk) begin
    if (wr_mem) begin
      for (int b = 0; b < SW; b++)
        if (bus.s_axi_wstrb[b]) mem[fill_bank][wr_widx][b*8 +: 8] <= bus.s_axi_wdata[b*8 +: 8];
    end
  end
endmodule

// File: tb/tb_ofdm_tx_input_buffer_pp.sv
// Bench for the OFDM Tx ping-pong input buffer. A symbol-level model
// (queue of committed words, count of full banks) predicts every output.
module tb_ofdm_tx_input_buffer_pp;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int N  = 7;
  localparam int HALF = 5;

  logic aclk = 1'b0;
  logic areset = 1'b1;

  ofdm_tx_input_buffer_pp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  ofdm_tx_input_buffer_pp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_SYMBOL(N)) dut (
    .aclk(aclk), .areset(areset), .bus(bus)
  );

  always #HALF aclk = ~aclk;

  int tests = 0, fails = 0;
  // model state
  int          m_cnt, m_pos;
  bit          m_fill, m_drain, m_ovf, m_bpend, m_rpend;
  logic [7:0]  m_sym;
  logic [1:0]  m_bresp;
  logic [31:0] m_rdata;
  logic [31:0] m_mem [2][N];
  logic [31:0] m_words [$];
  // observed beats
  logic [31:0] log_d [$];
  bit          log_l [$];
  time         log_t [$];
  time         acc_t;
  bit          rnd_ready = 0, rnd_b = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    tests++; fails++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  function automatic logic [31:0] m_status();
    logic [1:0] full;
    full = 2'b00;
    if (m_cnt == 1) full[m_drain] = 1'b1;
    else if (m_cnt == 2) full = 2'b11;
    return {16'h0, m_sym, 3'b000, m_ovf, m_drain, m_fill, full};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pos = 0; m_fill = 0; m_drain = 0; m_ovf = 0;
    m_sym = 0; m_bpend = 0; m_rpend = 0; m_bresp = 0; m_rdata = 0;
    m_words.delete();
  endtask

  task automatic model_edge();
    bit wacc, racc, beat;
    logic [31:0] st;
    int pre, idx;
    wacc = bus.s_axi_awvalid && bus.s_axi_wvalid && !m_bpend;
    racc = bus.s_axi_arvalid && !m_rpend;
    beat = (m_cnt > 0) && bus.m_axis_tready;
    st = m_status();
    pre = m_cnt;
    if (m_bpend && bus.s_axi_bready) m_bpend = 0;
    if (m_rpend && bus.s_axi_rready) m_rpend = 0;
    if (racc) begin
      m_rpend = 1;
      m_rdata = (int'(bus.s_axi_araddr[7:2]) == 63) ? st : 32'h0;
    end
    if (beat) begin
      void'(m_words.pop_front());
      m_pos++;
      if (m_pos == N) begin m_pos = 0; m_cnt--; m_drain = !m_drain; end
    end
    if (wacc) begin
      idx = int'(bus.s_axi_awaddr[7:2]);
      m_bpend = 1; m_bresp = 2'b00;
      if (idx < N) begin
        if (pre == 2) begin
          m_bresp = 2'b10; m_ovf = 1;
        end else begin
          for (int b = 0; b < 4; b++)
            if (bus.s_axi_wstrb[b]) m_mem[m_fill][idx][b*8 +: 8] = bus.s_axi_wdata[b*8 +: 8];
          if (idx == N - 1) begin
            for (int i = 0; i < N; i++) m_words.push_back(m_mem[m_fill][i]);
            m_cnt++; m_fill = !m_fill; m_sym++;
          end
        end
      end else if (idx == 63 && bus.s_axi_wstrb[0] && bus.s_axi_wdata[0]) begin
        m_ovf = 0;
      end
    end
  endtask

  task automatic compare();
    bit etv;
    if (areset) begin
      chk("rst_tvalid", 32'(bus.m_axis_tvalid), 0);
      chk("rst_tdata", bus.m_axis_tdata, 0);
      chk("rst_bvalid", 32'(bus.s_axi_bvalid), 0);
      chk("rst_rvalid", 32'(bus.s_axi_rvalid), 0);
      chk("rst_awready", 32'(bus.s_axi_awready), 0);
    end else begin
      etv = (m_cnt > 0);
      chk("tvalid", 32'(bus.m_axis_tvalid), 32'(etv));
      if (etv && m_words.size() > 0) begin
        chk("tdata", bus.m_axis_tdata, m_words[0]);
        chk("tlast", 32'(bus.m_axis_tlast), 32'(m_pos == N - 1));
      end
      chk("awready", 32'(bus.s_axi_awready), 32'(bus.s_axi_awvalid && bus.s_axi_wvalid && !m_bpend));
      chk("wready", 32'(bus.s_axi_wready), 32'(bus.s_axi_awvalid && bus.s_axi_wvalid && !m_bpend));
      chk("bvalid", 32'(bus.s_axi_bvalid), 32'(m_bpend));
      if (m_bpend) chk("bresp", 32'(bus.s_axi_bresp), 32'(m_bresp));
      chk("arready", 32'(bus.s_axi_arready), 32'(bus.s_axi_arvalid && !m_rpend));
      chk("rvalid", 32'(bus.s_axi_rvalid), 32'(m_rpend));
      if (m_rpend) begin
        chk("rdata", bus.s_axi_rdata, m_rdata);
        chk("rresp", 32'(bus.s_axi_rresp), 0);
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        log_d.push_back(bus.m_axis_tdata);
        log_l.push_back(bus.m_axis_tlast);
        log_t.push_back($time + HALF);
      end
    end
  endtask

  initial forever begin
    @(posedge aclk or posedge areset);
    if (areset) model_reset();
    else        model_edge();
  end

  initial forever begin
    @(negedge aclk);
    compare();
  end

  initial forever begin
    @(posedge aclk); #1;
    if (rnd_ready) bus.m_axis_tready = 1'($urandom_range(0, 1));
  end

  task automatic wr(input logic [5:0] idx, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    int n;
    bus.s_axi_awaddr = {idx, 2'($urandom_range(0, 3))};
    bus.s_axi_wdata = d; bus.s_axi_wstrb = s;
    bus.s_axi_awvalid = 1; bus.s_axi_wvalid = 1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!bus.s_axi_awready && n < 200);
    if (n >= 200) timeout("wr_accept");
    @(posedge aclk); acc_t = $time; #1;
    bus.s_axi_awvalid = 0; bus.s_axi_wvalid = 0;
    if (rnd_b) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
    bus.s_axi_bready = 1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!bus.s_axi_bvalid && n < 200);
    if (n >= 200) timeout("wr_bvalid");
    resp = bus.s_axi_bresp;
    @(posedge aclk); #1;
    bus.s_axi_bready = 0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    int n;
    bus.s_axi_araddr = a; bus.s_axi_arvalid = 1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!bus.s_axi_arready && n < 200);
    if (n >= 200) timeout("rd_accept");
    @(posedge aclk); #1;
    bus.s_axi_arvalid = 0;
    if (rnd_b) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
    bus.s_axi_rready = 1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!bus.s_axi_rvalid && n < 200);
    if (n >= 200) timeout("rd_rvalid");
    d = bus.s_axi_rdata;
    @(posedge aclk); #1;
    bus.s_axi_rready = 0;
  endtask

  task automatic put_sym(input logic [31:0] base);
    logic [1:0] r;
    for (int i = 0; i < N; i++) begin
      wr(6'(i), base + 32'(i), 4'hF, r);
      chk("sym_bresp", 32'(r), 0);
    end
  endtask

  task automatic wait_beats(input int k);
    int n;
    n = 0;
    while (log_d.size() < k && n < 500) begin @(negedge aclk); n++; end
    if (n >= 500) timeout("wait_beats");
    @(posedge aclk); #1;
  endtask

  task automatic clr_log();
    log_d.delete(); log_l.delete(); log_t.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] st;
    int n;
    bus.s_axi_awaddr = 0; bus.s_axi_awvalid = 0; bus.s_axi_wdata = 0; bus.s_axi_wstrb = 0;
    bus.s_axi_wvalid = 0; bus.s_axi_bready = 0; bus.s_axi_araddr = 0; bus.s_axi_arvalid = 0;
    bus.s_axi_rready = 0; bus.m_axis_tready = 0;
    repeat (3) @(posedge aclk);
    #1 areset = 0;

    // 1: alternating all-ones / zeros symbol, streamed with tready high
    rd(8'hFC, st); chk("t1_status_reset", st, 32'h0);
    bus.m_axis_tready = 1;
    clr_log();
    for (int i = 0; i < N; i++) begin
      wr(6'(i), (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0, 4'hF, r);
      chk("t1_bresp", 32'(r), 0);
    end
    wait_beats(N);
    for (int i = 0; i < N; i++) begin
      chk("t1_word", log_d[i], (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0);
      chk("t1_tlast", 32'(log_l[i]), 32'(i == N - 1));
    end
    rd(8'hFC, st); chk("t1_status", st, 32'h0000_010C);

    // 2: two committed symbols with the stream stalled, then overflow
    bus.m_axis_tready = 0;
    put_sym(32'h1);
    put_sym(32'h11);
    wr(6'd0, 32'hDEAD_BEEF, 4'hF, r); chk("t2_ovf_bresp", 32'(r), 32'h2);
    rd(8'hFC, st); chk("t2_status", st, 32'h0000_031F);
    clr_log();
    bus.m_axis_tready = 1;
    wait_beats(2 * N);
    for (int i = 0; i < 2 * N; i++) begin
      chk("t2_word", log_d[i], (i < N) ? 32'(i + 1) : 32'(32'h11 + i - N));
      chk("t2_tlast", 32'(log_l[i]), 32'(i == N - 1 || i == 2 * N - 1));
    end
    chk("t2_no_bubble", 32'(log_t[2*N-1] - log_t[0]), 32'((2 * N - 1) * 2 * HALF));
    wr(6'd63, 32'h1, 4'h1, r); chk("t2_ctrl_bresp", 32'(r), 0);
    rd(8'hFC, st); chk("t2_ovf_cleared", st & 32'h10, 0);

    // 3: tready toggling every cycle
    bus.m_axis_tready = 0;
    put_sym(32'h100);
    clr_log();
    n = 0;
    while (log_d.size() < N && n < 60) begin
      bus.m_axis_tready = ~bus.m_axis_tready;
      @(posedge aclk); #1; n++;
    end
    bus.m_axis_tready = 0;
    chk("t3_beats", 32'(log_d.size()), 32'(N));
    for (int i = 0; i < N && i < log_d.size(); i++) chk("t3_word", log_d[i], 32'h100 + 32'(i));

    // 4: partial byte-strobe write
    wr(6'd0, 32'hFFFF_FFFF, 4'hF, r);
    wr(6'd0, 32'hAABB_CCDD, 4'h3, r);
    for (int i = 1; i < N; i++) wr(6'(i), 32'h600 + 32'(i), 4'hF, r);
    clr_log();
    bus.m_axis_tready = 1;
    wait_beats(N);
    chk("t4_word0", log_d[0], 32'hFFFF_CCDD);
    chk("t4_word1", log_d[1], 32'h601);

    // 5: commit lands on the same edge as the last beat of the other bank
    bus.m_axis_tready = 0;
    clr_log();
    put_sym(32'h200);
    for (int i = 0; i < N - 1; i++) wr(6'(i), 32'h300 + 32'(i), 4'hF, r);
    bus.m_axis_tready = 1;
    repeat (N - 1) @(posedge aclk);
    #1;
    wr(6'(N - 1), 32'h300 + 32'(N - 1), 4'hF, r);
    chk("t5_bresp", 32'(r), 0);
    wait_beats(2 * N);
    chk("t5_coincide", 32'(acc_t), 32'(log_t[N-1]));
    chk("t5_no_bubble", 32'(log_t[N] - log_t[N-1]), 32'(2 * HALF));
    for (int i = 0; i < N; i++) chk("t5_word", log_d[N+i], 32'h300 + 32'(i));
    rd(8'hFC, st); chk("t5_flags", st & 32'h3, 0);

    // 6: reset mid-stream
    bus.m_axis_tready = 0;
    put_sym(32'h400);
    clr_log();
    bus.m_axis_tready = 1;
    wait_beats(3);
    #1 areset = 1;
    #1;
    chk("t6_tvalid", 32'(bus.m_axis_tvalid), 0);
    chk("t6_tdata", bus.m_axis_tdata, 0);
    repeat (2) @(posedge aclk);
    #1 areset = 0;
    rd(8'hFC, st); chk("t6_status", st, 32'h0);
    clr_log();
    put_sym(32'h500);
    wait_beats(N);
    for (int i = 0; i < N; i++) chk("t6_word", log_d[i], 32'h500 + 32'(i));

    // random traffic against the model
    rnd_ready = 1; rnd_b = 1;
    repeat (300) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: wr(6'($urandom_range(0, N - 1)), $urandom, 4'($urandom_range(0, 15)), r);
        6:                wr(6'($urandom_range(N, 62)), $urandom, 4'hF, r);
        7:                wr(6'd63, 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), r);
        default:          rd(($urandom_range(0, 1) == 1) ? 8'($urandom_range(252, 255)) : 8'($urandom), st);
      endcase
    end
    rnd_ready = 0; rnd_b = 0;
    @(posedge aclk); #1;
    bus.m_axis_tready = 1;
    n = 0;
    while (m_cnt > 0 && n < 100) begin @(posedge aclk); #1; n++; end
    if (n >= 100) timeout("final_drain");
    repeat (2) @(posedge aclk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
